// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmitter arbiter.
// State encoding and default sizing used by uart_tx_arbiter and its testbench.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } arb_state_e;

    localparam int NREQ_DEFAULT     = 4;
    localparam int START_TO_DEFAULT = 15;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational rotate-search arbiter. Returns the first asserted
// request at or above ptr_i, wrapping NREQ-1 -> 0, as one-hot, index and valid.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            vld_o
);

    logic [PW-1:0] cand;

    // Explicit wrap compare so non-power-of-two NREQ never visits a missing slot.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = ptr_i;
        for (int i = 0; i < NREQ; i++) begin
            if (!vld_o && req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = cand;
            end
            cand = (cand == PW'(NREQ - 1)) ? '0 : cand + PW'(1);
        end
        if (vld_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, byte-at-a-time sharing of one UART TX engine among NREQ requesters.
// Define UART_ARB_LOCK_EN to let the current owner keep priority while it keeps requesting.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEFAULT,
    parameter int START_TO = START_TO_DEFAULT,
    parameter int CW       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_data,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_tx_load,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_rdy,
    output logic              o_busy,
    output logic              o_fault
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   g_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] grant_q;
    logic            load_q;
    logic [7:0]      data_q;
    logic            busy_q;
    logic            fault_q;
    logic [CW-1:0]   cnt_q;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_vld;
    logic [PW-1:0]   ptr_d;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

`ifdef UART_ARB_LOCK_EN
    assign ptr_d = g_q;
`else
    assign ptr_d = (g_q == PW'(NREQ - 1)) ? '0 : g_q + PW'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            load_q  <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_vld && i_tx_rdy) begin
                        g_q     <= pick_idx;
                        grant_q <= pick_gnt;
                        data_q  <= i_data[8*pick_idx +: 8];
                        ack_q   <= pick_gnt;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    ack_q   <= '0;
                    load_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    cnt_q   <= '0;
                    state_q <= WAIT_LO;
                end
                // Engine must acknowledge the load by dropping ready within START_TO cycles.
                WAIT_LO: begin
                    if (!i_tx_rdy) begin
                        state_q <= WAIT_HI;
                    end else if (cnt_q == CW'(START_TO - 1)) begin
                        fault_q <= 1'b1;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_HI: begin
                    if (i_tx_rdy) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ack     = ack_q;
    assign o_grant   = grant_q;
    assign o_tx_load = load_q;
    assign o_tx_data = data_q;
    assign o_busy    = busy_q;
    assign o_fault   = fault_q;

endmodule
